// File: rtl/alu_seq_mult16_pkg.sv
// Shared ALU definitions: multiplier width, step-counter width, FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_seq_mult16_pkg;

  localparam int MUL_WIDTH = 16;
  // One counter value per iteration; wraps only because every run reloads it.
  localparam int CNT_W     = $clog2(MUL_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu_seq_mult16_cla.sv
// 16-bit carry-look-ahead adder: 4-bit groups with group generate/propagate.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of a, b, cin.
// Ports: a, b (addends), cin (carry in), sum (a+b+cin low bits), cout (carry out).
module carry_look_ahead16bit
  import alu_seq_mult16_pkg::*;
(
  input  logic [MUL_WIDTH-1:0] a,
  input  logic [MUL_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [MUL_WIDTH-1:0] sum,
  output logic                 cout
);

  localparam int NG = MUL_WIDTH / 4;

  logic [MUL_WIDTH-1:0] g;
  logic [MUL_WIDTH-1:0] p;
  logic [NG-1:0]        gg;
  logic [NG-1:0]        gp;
  logic [NG:0]          gc;
  logic [MUL_WIDTH:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    // Group generate/propagate from the bit-level terms.
    for (int j = 0; j < NG; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    // Group carries skip whole 4-bit blocks.
    gc[0] = cin;
    for (int j = 0; j < NG; j++) begin
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
    // Bit carries inside each group start from that group's carry-in.
    for (int j = 0; j < NG; j++) begin
      c[4*j] = gc[j];
      for (int k = 0; k < 3; k++) begin
        c[4*j+k+1] = g[4*j+k] | (p[4*j+k] & c[4*j+k]);
      end
    end
    c[MUL_WIDTH] = gc[NG];
  end

  assign sum  = p ^ c[MUL_WIDTH-1:0];
  assign cout = c[MUL_WIDTH];

endmodule

// File: rtl/alu_seq_mult16.sv
// Sequential unsigned shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one CLA add per cycle.
// Latency: product/done at WIDTH edges after start acceptance; one multiply per WIDTH+1 cycles.
// Backpressure: start is ignored while busy; accepted in IDLE or in the DONE cycle.
// Ports: clk, rst_n (async active-low), start, a (multiplicand), b (multiplier),
//        busy (iterating), done (one-cycle completion pulse), product (result hold register).
module alu_seq_mult16
  import alu_seq_mult16_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  mul_state_e       state;
  mul_state_e       state_nxt;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             load;
  logic             step;
  logic             last;

  // Add the multiplicand only when the current multiplier LSB is set.
  assign addend = q[0] ? mcand : '0;

  carry_look_ahead16bit u_cla (
    .a    (acc),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // {cout,sum,q} >> 1: the carry lands in acc's MSB, so the product is exact.
  assign acc_nxt = {cout, sum[WIDTH-1:1]};
  assign q_nxt   = {sum[0], q[WIDTH-1:1]};
  assign last    = (cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        // A start here chains straight into the next run with no idle gap.
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc     <= '0;
      q       <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (load) begin
      mcand <= a;
      acc   <= '0;
      q     <= b;
      cnt   <= '0;
    end else if (step) begin
      acc <= acc_nxt;
      q   <= q_nxt;
      cnt <= cnt + CNT_W'(1);
      // product only moves on the completion edge; it holds through later runs.
      if (last) begin
        product <= {acc_nxt, q_nxt};
      end
    end
  end

endmodule
